// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush and bubble counter
// Optional Rs field enabled by macro ID_EX_RS_FIELD_EN.
module id_ex_pipe_reg #(
  parameter int ALUOP_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [31:0]        ReadData1_in,
  input  logic [31:0]        ReadData2_in,
  input  logic [31:0]        SignExt_in,
  input  logic [31:0]        PCPlus4_in,
  input  logic [4:0]         Rt_in,
  input  logic [4:0]         Rd_in,
  input  logic               RegWrite_in,
  input  logic               MemtoReg_in,
  input  logic               MemRead_in,
  input  logic               MemWrite_in,
  input  logic               Branch_in,
  input  logic               ALUSrc_in,
  input  logic               RegDst_in,
  input  logic [ALUOP_W-1:0] ALUOp_in,
  input  logic               Valid_in,
  output logic [31:0]        ReadData1_out,
  output logic [31:0]        ReadData2_out,
  output logic [31:0]        SignExt_out,
  output logic [31:0]        PCPlus4_out,
  output logic [4:0]         Rt_out,
  output logic [4:0]         Rd_out,
  output logic               RegWrite_out,
  output logic               MemtoReg_out,
  output logic               MemRead_out,
  output logic               MemWrite_out,
  output logic               Branch_out,
  output logic               ALUSrc_out,
  output logic               RegDst_out,
  output logic [ALUOP_W-1:0] ALUOp_out,
  output logic               Valid_out,
`ifdef ID_EX_RS_FIELD_EN
  input  logic [4:0]         Rs_in,
  output logic [4:0]         Rs_out,
`endif
  output logic [7:0]         BubbleCount
);

  localparam int PW = 32 * 4 + 5 * 2 + 7 + ALUOP_W + 1;

  logic [PW-1:0] stage_in;
  logic [PW-1:0] stage_d, stage_q;
  logic [7:0]    bubble_d, bubble_q;
  logic [7:0]    bubble_inc;

  assign stage_in = {ReadData1_in, ReadData2_in, SignExt_in, PCPlus4_in, Rt_in, Rd_in,
                     RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in,
                     ALUSrc_in, RegDst_in, ALUOp_in, Valid_in};

  assign bubble_inc = (bubble_q == 8'hFF) ? bubble_q : bubble_q + 8'd1;

  // Priority: Reset > Flush > Stall > Load
  always_comb begin
    stage_d  = stage_q;
    bubble_d = bubble_q;
    if (Reset) begin
      stage_d  = '0;
      bubble_d = 8'd0;
    end else if (Flush) begin
      stage_d  = '0;
      bubble_d = bubble_inc;
    end else if (!Stall) begin
      stage_d = stage_in;
      if (!Valid_in) bubble_d = bubble_inc;
    end
  end

  always_ff @(posedge Clk) begin
    stage_q  <= stage_d;
    bubble_q <= bubble_d;
  end

  assign {ReadData1_out, ReadData2_out, SignExt_out, PCPlus4_out, Rt_out, Rd_out,
          RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out,
          ALUSrc_out, RegDst_out, ALUOp_out, Valid_out} = stage_q;
  assign BubbleCount = bubble_q;

`ifdef ID_EX_RS_FIELD_EN
  logic [4:0] rs_d, rs_q;

  always_comb begin
    rs_d = rs_q;
    if (Reset || Flush) rs_d = 5'd0;
    else if (!Stall)    rs_d = Rs_in;
  end

  always_ff @(posedge Clk) begin
    rs_q <= rs_d;
  end

  assign Rs_out = rs_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic [31:0] pc4;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [6:0]  ctl;
    logic [3:0]  aluop;
    logic        valid;
    logic [4:0]  rs;
    logic [7:0]  bc;
  } snap_t;

  logic Clk = 0;
  logic Reset, Stall, Flush;
  snap_t in_s, obs_s, m;
  snap_t exp_q[$];
  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  id_ex_pipe_reg #(.ALUOP_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ReadData1_in(in_s.rd1), .ReadData2_in(in_s.rd2), .SignExt_in(in_s.se), .PCPlus4_in(in_s.pc4),
    .Rt_in(in_s.rt), .Rd_in(in_s.rd),
    .RegWrite_in(in_s.ctl[6]), .MemtoReg_in(in_s.ctl[5]), .MemRead_in(in_s.ctl[4]),
    .MemWrite_in(in_s.ctl[3]), .Branch_in(in_s.ctl[2]), .ALUSrc_in(in_s.ctl[1]),
    .RegDst_in(in_s.ctl[0]), .ALUOp_in(in_s.aluop), .Valid_in(in_s.valid),
    .ReadData1_out(obs_s.rd1), .ReadData2_out(obs_s.rd2), .SignExt_out(obs_s.se),
    .PCPlus4_out(obs_s.pc4), .Rt_out(obs_s.rt), .Rd_out(obs_s.rd),
    .RegWrite_out(obs_s.ctl[6]), .MemtoReg_out(obs_s.ctl[5]), .MemRead_out(obs_s.ctl[4]),
    .MemWrite_out(obs_s.ctl[3]), .Branch_out(obs_s.ctl[2]), .ALUSrc_out(obs_s.ctl[1]),
    .RegDst_out(obs_s.ctl[0]), .ALUOp_out(obs_s.aluop), .Valid_out(obs_s.valid),
`ifdef ID_EX_RS_FIELD_EN
    .Rs_in(in_s.rs), .Rs_out(obs_s.rs),
`endif
    .BubbleCount(obs_s.bc)
  );

`ifndef ID_EX_RS_FIELD_EN
  assign obs_s.rs = 5'd0;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic cyc(input logic rst, input logic fl, input logic st, input bit chk);
    snap_t e;
    Reset = rst; Flush = fl; Stall = st;
    @(posedge Clk);
    if (rst) m = '0;
    else if (fl) m = '{bc: sat_inc(m.bc), default: '0};
    else if (!st) begin
      m = '{rd1: in_s.rd1, rd2: in_s.rd2, se: in_s.se, pc4: in_s.pc4, rt: in_s.rt, rd: in_s.rd,
            ctl: in_s.ctl, aluop: in_s.aluop, valid: in_s.valid, rs: 5'd0,
            bc: in_s.valid ? m.bc : sat_inc(m.bc)};
`ifdef ID_EX_RS_FIELD_EN
      m.rs = in_s.rs;
`endif
    end
    exp_q.push_back(m);
    #1;
    if (chk) begin
      e = exp_q.pop_front();
      tests++;
      if ({obs_s.rd1, obs_s.rd2, obs_s.pc4} !== {e.rd1, e.rd2, e.pc4}) begin
        fails++; $error("FAIL data obs=%0h exp=%0h", {obs_s.rd1, obs_s.rd2, obs_s.pc4}, {e.rd1, e.rd2, e.pc4});
      end
      tests++;
      if (obs_s.se !== e.se) begin
        fails++; $error("FAIL signext obs=%0h exp=%0h", obs_s.se, e.se);
      end
      tests++;
      if ({obs_s.rt, obs_s.rd, obs_s.rs} !== {e.rt, e.rd, e.rs}) begin
        fails++; $error("FAIL regs obs=%0h exp=%0h", {obs_s.rt, obs_s.rd, obs_s.rs}, {e.rt, e.rd, e.rs});
      end
      tests++;
      if ({obs_s.ctl, obs_s.aluop, obs_s.valid} !== {e.ctl, e.aluop, e.valid}) begin
        fails++; $error("FAIL ctl obs=%0h exp=%0h", {obs_s.ctl, obs_s.aluop, obs_s.valid}, {e.ctl, e.aluop, e.valid});
      end
      tests++;
      if (obs_s.bc !== e.bc) begin
        fails++; $error("FAIL bubble obs=%0h exp=%0h", obs_s.bc, e.bc);
      end
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    m = '0;
    in_s = '1;
    Reset = 1; Flush = 0; Stall = 0;
    cyc(1, 1, 1, 1);
    tests++;
    if (obs_s.bc !== 8'd0) begin
      fails++; $error("FAIL reset_bc obs=%0h exp=%0h", obs_s.bc, 8'd0);
    end

    in_s = '0;
    in_s.se = 32'hFFFF8000; in_s.ctl[6] = 1'b1; in_s.aluop = 4'h2; in_s.valid = 1'b1;
    in_s.rd1 = 32'hDEADBEEF; in_s.rt = 5'd9; in_s.rs = 5'd17;
    cyc(0, 0, 0, 1);
    tests++;
    if (obs_s.se !== 32'hFFFF8000) begin
      fails++; $error("FAIL ld_se obs=%0h exp=%0h", obs_s.se, 32'hFFFF8000);
    end
    tests++;
    if ({obs_s.ctl[6], obs_s.aluop, obs_s.valid} !== {1'b1, 4'h2, 1'b1}) begin
      fails++; $error("FAIL ld_ctl obs=%0h exp=%0h", {obs_s.ctl[6], obs_s.aluop, obs_s.valid}, {1'b1, 4'h2, 1'b1});
    end
`ifdef ID_EX_RS_FIELD_EN
    tests++;
    if (obs_s.rs !== 5'd17) begin
      fails++; $error("FAIL rs_load obs=%0h exp=%0h", obs_s.rs, 5'd17);
    end
`endif

    in_s.se = 32'h00001234; in_s.rd2 = 32'h00001234; in_s.aluop = 4'h7;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    tests++;
    if (obs_s.se !== 32'hFFFF8000) begin
      fails++; $error("FAIL stall_hold obs=%0h exp=%0h", obs_s.se, 32'hFFFF8000);
    end
    cyc(0, 0, 0, 1);
    tests++;
    if (obs_s.se !== 32'h00001234) begin
      fails++; $error("FAIL stall_rel obs=%0h exp=%0h", obs_s.se, 32'h00001234);
    end

    in_s.ctl[3] = 1'b1;
    cyc(0, 1, 1, 1);
    tests++;
    if ({obs_s.ctl[3], obs_s.valid, obs_s.bc} !== {1'b0, 1'b0, 8'd1}) begin
      fails++; $error("FAIL flush_mw obs=%0h exp=%0h", {obs_s.ctl[3], obs_s.valid, obs_s.bc}, {1'b0, 1'b0, 8'd1});
    end
`ifdef ID_EX_RS_FIELD_EN
    tests++;
    if (obs_s.rs !== 5'd0) begin
      fails++; $error("FAIL rs_flush obs=%0h exp=%0h", obs_s.rs, 5'd0);
    end
`endif

    in_s.ctl = 7'h7F; in_s.valid = 1'b0;
    cyc(0, 0, 0, 1);
    tests++;
    if ({obs_s.ctl, obs_s.valid, obs_s.bc} !== {7'h7F, 1'b0, 8'd2}) begin
      fails++; $error("FAIL inv_ctl obs=%0h exp=%0h", {obs_s.ctl, obs_s.valid, obs_s.bc}, {7'h7F, 1'b0, 8'd2});
    end

    for (int i = 0; i < 20; i++) begin
      in_s.rd1 = $urandom; in_s.rd2 = $urandom; in_s.se = $urandom; in_s.pc4 = $urandom;
      in_s.rt = 5'($urandom); in_s.rd = 5'($urandom); in_s.rs = 5'($urandom);
      in_s.ctl = 7'($urandom); in_s.aluop = 4'($urandom); in_s.valid = 1'($urandom);
      cyc(0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), 1);
    end

    in_s.valid = 1'b1; in_s.se = 32'hA5A5A5A5;
    cyc(0, 0, 0, 1);
    in_s.se = 32'h5A5A5A5A;
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    tests++;
    if ({obs_s.se, obs_s.valid, obs_s.bc} !== {32'h0, 1'b0, 8'd0}) begin
      fails++; $error("FAIL rst_stall obs=%0h exp=%0h", {obs_s.se, obs_s.valid, obs_s.bc}, {32'h0, 1'b0, 8'd0});
    end
    cyc(0, 0, 0, 1);
    tests++;
    if (obs_s.se !== 32'h5A5A5A5A) begin
      fails++; $error("FAIL post_rst obs=%0h exp=%0h", obs_s.se, 32'h5A5A5A5A);
    end

    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, i[0], (i < 3) || (i > 250));
      if (i == 254) begin
        tests++;
        if (obs_s.bc !== 8'd255) begin
          fails++; $error("FAIL bc_255 obs=%0h exp=%0h", obs_s.bc, 8'd255);
        end
      end
    end
    tests++;
    if (obs_s.bc !== 8'd255) begin
      fails++; $error("FAIL bc_sat obs=%0h exp=%0h", obs_s.bc, 8'd255);
    end
    in_s.valid = 1'b0;
    cyc(0, 0, 0, 1);
    tests++;
    if (obs_s.bc !== 8'd255) begin
      fails++; $error("FAIL bc_sat_ld obs=%0h exp=%0h", obs_s.bc, 8'd255);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 4, the ALUOp control field width.
REQ-002 The block SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 The block SHALL have port Stall  input  1  hold all registered contents.
REQ-005 The block SHALL have port Flush  input  1  load a bubble instead of the ID-stage inputs.
REQ-006 The block SHALL have ports ReadData1_in, ReadData2_in, SignExt_in, PCPlus4_in  input  32 each  register-file operands, 32-bit sign-extended immediate, and PC+4 from ID.
REQ-007 The block SHALL have ports Rt_in, Rd_in  input  5 each  destination register candidates.
REQ-008 The block SHALL have ports RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, ALUSrc_in, RegDst_in  input  1 each  ID control bits.
REQ-009 The block SHALL have port ALUOp_in  input  ALUOP_W  ALU operation code.
REQ-010 The block SHALL have port Valid_in  input  1  ID slot holds a real instruction.
REQ-011 The block SHALL have, for each *_in port in REQ-006..REQ-010, a matching *_out output of equal width, registered.
REQ-012 The block SHALL have port BubbleCount  output  8  saturating count of bubbles entering EX.

Function
REQ-013 Each rising Clk, the block SHALL apply exactly one action by priority: Reset, then Flush, then Stall, then Load.
REQ-014 Load SHALL copy every *_in to its *_out; latency exactly one Clk cycle.
REQ-015 Stall (Flush=0) SHALL hold every *_out and BubbleCount unchanged.
REQ-016 Flush SHALL clear all control outputs (REQ-008, ALUOp_out) and Valid_out to 0, and all data outputs (REQ-006, REQ-007) to 0.
REQ-017 Flush and Stall both high SHALL behave as Flush.
REQ-018 BubbleCount SHALL increment by 1 on a Flush cycle or on a Load cycle with Valid_in=0.
REQ-019 BubbleCount SHALL saturate at 255; no wrap to 0.
REQ-020 A Load with Valid_in=0 SHALL pass control bits unchanged; consumers gate on Valid_out.
REQ-021 SignExt_out SHALL carry all 32 bits of SignExt_in unmodified; no extension or truncation here.
REQ-022 Outputs SHALL depend only on registered state; no combinational in-to-out path.

Reset
REQ-023 Reset high at a rising Clk SHALL set every *_out and BubbleCount to 0 regardless of Stall/Flush.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; the first Load after Reset deasserts captures current inputs.

Configuration
REQ-025 With macro ID_EX_RS_FIELD_EN defined, the block SHALL add ports Rs_in input 5 and Rs_out output 5, loaded, held, flushed to 0, and reset to 0 exactly like Rt.
REQ-026 Without ID_EX_RS_FIELD_EN, Rs_in/Rs_out SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-027 Reset=1 one cycle with all inputs 1s -> all outputs 0, BubbleCount=0.
REQ-028 Load SignExt_in=32'hFFFF8000, RegWrite_in=1, ALUOp_in=4'h2, Valid_in=1 -> next cycle SignExt_out=32'hFFFF8000, RegWrite_out=1, ALUOp_out=4'h2, Valid_out=1.
REQ-029 Stall=1 for 3 cycles while inputs change to 32'h00001234 -> outputs keep prior values; release -> 32'h00001234 appears one cycle later.
REQ-030 Flush=1 and Stall=1 together with MemWrite_in=1 -> MemWrite_out=0, Valid_out=0, BubbleCount +1.
REQ-031 Flush held 300 cycles -> BubbleCount reaches 255 and stays 255.
REQ-032 With ID_EX_RS_FIELD_EN, Rs_in=5'd17 loaded -> Rs_out=17; Flush -> Rs_out=0.
